// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch/decode register types and constants.
package riscv_pkg;
    typedef enum logic [1:0] {EMPTY, ONE, TWO} fd_state_t;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;
endpackage

// File: rtl/fetch_decode_reg_if.sv
// fetch_decode_reg_if: fetch-side and decode-side signals of the fetch/decode pipeline register.
interface fetch_decode_reg_if #(parameter int DATA_WIDTH = 32);
    logic [DATA_WIDTH-1:0] instrF_i, PCF_i, PCPlus4F_i;
    logic                  validF_i, readyF_o, stallD_i, flushD_i;
    logic [DATA_WIDTH-1:0] instrD_o, PCD_o, PCPlus4D_o;
    logic                  validD_o;
    modport master (
        output instrF_i, PCF_i, PCPlus4F_i, validF_i, stallD_i, flushD_i,
        input  readyF_o, instrD_o, PCD_o, PCPlus4D_o, validD_o
    );
    modport slave (
        input  instrF_i, PCF_i, PCPlus4F_i, validF_i, stallD_i, flushD_i,
        output readyF_o, instrD_o, PCD_o, PCPlus4D_o, validD_o
    );
endinterface

// File: rtl/fetch_decode_reg.sv
// fetch_decode_reg: 2-entry skid buffer between fetch and decode.
// Define FD_BUBBLE_NOP_EN to present a NOP on instrD_o whenever no instruction is valid.
module fetch_decode_reg
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input logic clk,
    input logic rst_n,
    fetch_decode_reg_if.slave bus
);
    fd_state_t state, state_nxt;
    logic [DATA_WIDTH-1:0] head_instr, head_pc, head_pc4;
    logic [DATA_WIDTH-1:0] skid_instr, skid_pc, skid_pc4;
    logic ready, accept, advance, load_head, load_skid, pop_skid;

    always_comb begin
        accept    = bus.validF_i & ready & ~bus.flushD_i;
        advance   = (state != EMPTY) & ~bus.stallD_i;
        load_head = accept & ((state == EMPTY) | (state == ONE & advance));
        load_skid = accept & (state == ONE) & ~advance;
        pop_skid  = (state == TWO) & advance & ~bus.flushD_i;
        state_nxt = bus.flushD_i ? EMPTY :
                    state == EMPTY ? (accept ? ONE : EMPTY) :
                    state == ONE ? (load_skid ? TWO : (advance & ~accept) ? EMPTY : ONE) :
                    (advance ? ONE : TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            ready      <= 1'b1;
            head_instr <= '0;
            head_pc    <= '0;
            head_pc4   <= '0;
            skid_instr <= '0;
            skid_pc    <= '0;
            skid_pc4   <= '0;
        end else begin
            state <= state_nxt;
            ready <= state_nxt != TWO;
            if (load_head) begin
                head_instr <= bus.instrF_i;
                head_pc    <= bus.PCF_i;
                head_pc4   <= bus.PCPlus4F_i;
            end else if (pop_skid) begin
                head_instr <= skid_instr;
                head_pc    <= skid_pc;
                head_pc4   <= skid_pc4;
            end
            if (load_skid) begin
                skid_instr <= bus.instrF_i;
                skid_pc    <= bus.PCF_i;
                skid_pc4   <= bus.PCPlus4F_i;
            end
        end
    end

    assign bus.readyF_o   = ready;
    assign bus.validD_o   = state != EMPTY;
    assign bus.PCD_o      = head_pc;
    assign bus.PCPlus4D_o = head_pc4;
`ifdef FD_BUBBLE_NOP_EN
    assign bus.instrD_o = (state != EMPTY) ? head_instr : DATA_WIDTH'(NOP_INSTR);
`else
    assign bus.instrD_o = head_instr;
`endif
endmodule

// File: tb/tb_fetch_decode_reg.sv
// tb_fetch_decode_reg: directed and scoreboard checks of the fetch/decode skid buffer.
module tb_fetch_decode_reg;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int fails = 0;

    fetch_decode_reg_if #(.DATA_WIDTH(32)) bus ();
    fetch_decode_reg #(.DATA_WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'hA500_0000 ^ pc;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic s, input logic f);
        bus.validF_i   = v;
        bus.PCF_i      = pc;
        bus.PCPlus4F_i = pc + 32'd4;
        bus.instrF_i   = instr_of(pc);
        bus.stallD_i   = s;
        bus.flushD_i   = f;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        chk("reset_valid", 32'(bus.validD_o), 32'd0);
        chk("reset_ready", 32'(bus.readyF_o), 32'd1);
        chk("reset_pc", bus.PCD_o, 32'd0);
`ifdef FD_BUBBLE_NOP_EN
        chk("reset_instr", bus.instrD_o, 32'h00000013);
`else
        chk("reset_instr", bus.instrD_o, 32'd0);
`endif
    endtask

    task automatic test_single();
        do_reset();
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        bus.instrF_i = 32'h00500093;
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("single_valid", 32'(bus.validD_o), 32'd1);
        chk("single_instr", bus.instrD_o, 32'h00500093);
        chk("single_pc", bus.PCD_o, 32'd0);
        chk("single_pc4", bus.PCPlus4D_o, 32'd4);
        tick();
        chk("single_drain", 32'(bus.validD_o), 32'd0);
    endtask

    task automatic test_skid();
        do_reset();
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h4, 1'b0, 1'b0);
        tick();
        chk("skid_pc4_head", bus.PCD_o, 32'h4);
        drive(1'b1, 32'h8, 1'b1, 1'b0);
        tick();
        chk("skid_two_ready", 32'(bus.readyF_o), 32'd0);
        chk("skid_two_pc", bus.PCD_o, 32'h4);
        drive(1'b1, 32'h8, 1'b1, 1'b0);
        tick();
        chk("skid_hold_pc", bus.PCD_o, 32'h4);
        chk("skid_hold_instr", bus.instrD_o, instr_of(32'h4));
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        chk("skid_drain_pc8", bus.PCD_o, 32'h8);
        chk("skid_drain_ready", 32'(bus.readyF_o), 32'd1);
        tick();
        chk("skid_no_dup", 32'(bus.validD_o), 32'd0);
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 32'h40, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h44, 1'b1, 1'b0);
        tick();
        chk("flush_pre_ready", 32'(bus.readyF_o), 32'd0);
        drive(1'b1, 32'h48, 1'b1, 1'b1);
        tick();
        chk("flush_valid", 32'(bus.validD_o), 32'd0);
        chk("flush_ready", 32'(bus.readyF_o), 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        chk("flush_dropped", 32'(bus.validD_o), 32'd0);
`ifdef FD_BUBBLE_NOP_EN
        chk("flush_instr", bus.instrD_o, 32'h00000013);
`else
        chk("flush_instr", bus.instrD_o, instr_of(32'h40));
`endif
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, 32'h80, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("areset_pre_valid", 32'(bus.validD_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("areset_valid", 32'(bus.validD_o), 32'd0);
        chk("areset_ready", 32'(bus.readyF_o), 32'd1);
        chk("areset_pc", bus.PCD_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'h90, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("areset_after_pc", bus.PCD_o, 32'h90);
        tick();
        chk("areset_after_empty", 32'(bus.validD_o), 32'd0);
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] tag = 32'd0;
        logic v, s, f, acc, adv;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            v = 1'($urandom_range(0, 3) != 0);
            s = 1'($urandom_range(0, 2) == 0);
            f = 1'($urandom_range(0, 15) == 0);
            drive(v, tag << 2, s, f);
            chk("rand_ready", 32'(bus.readyF_o), 32'(q.size() < 2));
            acc = v & (q.size() < 2) & ~f;
            adv = (q.size() > 0) & ~s;
            if (f) q.delete();
            else begin
                if (adv) void'(q.pop_front());
                if (acc) begin
                    q.push_back(tag << 2);
                    tag++;
                end
            end
            tick();
            chk("rand_valid", 32'(bus.validD_o), 32'(q.size() > 0));
            if (q.size() > 0) begin
                chk("rand_pc", bus.PCD_o, q[0]);
                chk("rand_instr", bus.instrD_o, instr_of(q[0]));
                chk("rand_pc4", bus.PCPlus4D_o, q[0] + 32'd4);
            end
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_skid();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
